pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word placed in the ID register on reset.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard stall; when 1, PC and ID registers hold.
REQ-006 im_instr  input  32  instruction read from instruction memory at pc_out.
REQ-007 npc_sel  input  2  next-PC select for the ID-stage instruction: 00 sequential, 01 conditional branch, 10 j/jal, 11 jr/jalr.
REQ-008 compare_out  input  1  branch-taken flag from the ID-stage branch comparator.
REQ-009 jr_target  input  32  forwarded rs value for jr/jalr.
REQ-010 pc_out  output  32  current fetch address to instruction memory.
REQ-011 id_instr  output  32  instruction held in the ID stage.
REQ-012 id_pc  output  32  address of id_instr.
REQ-013 id_pc8  output  32  id_pc + 8, the link address for jal/jalr/bgezal.
REQ-014 id_valid  output  1  1 when id_instr is a real fetched instruction, 0 for the reset bubble.

Function
REQ-015 The FSM SHALL have three states: BOOT, RUN and HOLD.
REQ-016 BOOT SHALL be entered on reset; on a clock edge with stall=0 it moves to RUN, and with stall=1 it stays in BOOT.
REQ-017 From RUN, stall=1 SHALL move to HOLD; from HOLD, stall=0 SHALL move to RUN.
REQ-018 Branch target SHALL be id_pc + 4 + (sign-extended id_instr[15:0] << 2), computed modulo 2^32.
REQ-019 Jump target SHALL be {id_pc[31:28], id_instr[25:0], 2'b00}.
REQ-020 The next PC SHALL be pc_out+4, except: branch target when npc_sel=01 and compare_out=1; jump target when npc_sel=10; jr_target when npc_sel=11.
REQ-021 npc_sel=01 with compare_out=0 SHALL select pc_out+4.
REQ-022 npc_sel and compare_out SHALL be ignored (sequential next PC) while id_valid=0.
REQ-023 On a clock edge with stall=0: pc_out<=next PC; id_instr<=im_instr; id_pc<=pc_out; id_valid<=1.
REQ-024 On a clock edge with stall=1: pc_out, id_instr, id_pc and id_valid SHALL hold; any redirect requested that cycle is not taken and is re-evaluated on the next cycle.
REQ-025 The branch delay slot is architectural: the instruction fetched while a branch/jump is in ID SHALL enter ID unchanged. No flush exists.
REQ-026 id_pc8 SHALL be combinationally id_pc+8, wrapping modulo 2^32.
REQ-027 A jr_target that is not word-aligned SHALL be loaded unmodified; alignment checking is out of scope.
REQ-028 Output latency: a redirect requested in cycle N (stall=0) SHALL appear on pc_out in cycle N+1.

Reset
REQ-029 While reset_n=0, the block SHALL hold: pc_out=RESET_PC, id_instr=NOP_INSTR, id_pc=RESET_PC, id_valid=0, state=BOOT.
REQ-030 A reset asserted mid-stall or mid-redirect SHALL take effect immediately, overriding all other inputs.
REQ-031 After reset_n deasserts, the first fetch address SHALL be RESET_PC.

Structure
REQ-032 The npc_sel encodings, FSM state encodings, RESET_PC default and NOP_INSTR default SHALL reside in the shared CPU package.
REQ-033 Next-PC computation SHALL be a combinational sub-module, npc_calc (inputs pc, id_pc, id_instr, npc_sel, compare_out, jr_target, id_valid; output next_pc). Registers and the FSM stay in pc_branch_unit.

Verification
REQ-034 Reset release, stall=0, npc_sel=00 for three cycles -> pc_out 3000, 3004, 3008; id_valid 0 then 1; id_pc8 = id_pc+8.
REQ-035 id_pc=3004, id_instr imm16=16'hFFFE, npc_sel=01, compare_out=1 -> next pc_out=3000; with compare_out=0 -> pc_out+4.
REQ-036 id_pc=3010, id_instr[25:0]=26'h0000C40, npc_sel=10 -> next pc_out=0000_3100; the delay-slot instruction enters ID with id_pc=3014.
REQ-037 npc_sel=11, jr_target=0000_3ABC, stall=1 for two cycles then 0 -> pc_out holds, then 0000_3ABC one cycle after stall drops.
REQ-038 Branch taken at id_pc=FFFF_FFF8 with imm16=16'h0001 -> pc_out=0000_0000 (wraps); reset_n pulsed low mid-stall -> outputs return immediately to reset values.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared CPU package: next-PC select codes, fetch FSM states
// and reset defaults for the PC/branch unit.
package pc_branch_unit_pkg;

    localparam int NPC_W = 2;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [NPC_W-1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Fetch/ID bundle between the PC unit and the rest of the pipeline.
// master = PC unit side, slave = pipeline/memory side.
interface pc_branch_unit_if;
    import pc_branch_unit_pkg::*;

    logic                   stall;
    logic [31:0]            im_instr;
    logic [NPC_W-1:0]       npc_sel;
    logic                   compare_out;
    logic [31:0]            jr_target;
    logic [31:0]            pc_out;
    logic [31:0]            id_instr;
    logic [31:0]            id_pc;
    logic [31:0]            id_pc8;
    logic                   id_valid;

    modport master (
        input  stall, im_instr, npc_sel, compare_out, jr_target,
        output pc_out, id_instr, id_pc, id_pc8, id_valid
    );

    modport slave (
        output stall, im_instr, npc_sel, compare_out, jr_target,
        input  pc_out, id_instr, id_pc, id_pc8, id_valid
    );

endinterface

// File: rtl/pc_branch_unit_npc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Redirects come from the instruction currently in ID.
module npc_calc
    import pc_branch_unit_pkg::*;
(
    input  logic [31:0]      pc,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_instr,
    input  logic [NPC_W-1:0] npc_sel,
    input  logic             compare_out,
    input  logic [31:0]      jr_target,
    input  logic             id_valid,
    output logic [31:0]      next_pc
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] br_pc;
    logic [31:0] j_pc;
    logic        take_br;
    logic        take_j;
    logic        take_jr;

    assign seq_pc = pc + 32'd4;
    assign br_off = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign br_pc  = id_pc + 32'd4 + br_off;
    assign j_pc   = {id_pc[31:28], id_instr[25:0], 2'b00};

    // The reset bubble in ID must never redirect fetch.
    assign take_br = id_valid && (npc_sel == NPC_BR) && compare_out;
    assign take_j  = id_valid && (npc_sel == NPC_J);
    assign take_jr = id_valid && (npc_sel == NPC_JR);

    always_comb begin
        next_pc = seq_pc;
        unique case (1'b1)
            take_br: next_pc = br_pc;
            take_j:  next_pc = j_pc;
            take_jr: next_pc = jr_target;
            default: next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, IF/ID register and fetch FSM.
// Delay slot is architectural: nothing is ever flushed.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    pc_branch_unit_if.master  bus
);

    state_e      state_q;
    state_e      state_d;
    logic        load;
    logic [31:0] pc_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc_q;
    logic        id_valid_q;
    logic [31:0] next_pc;

    npc_calc u_npc_calc (
        .pc          (pc_q),
        .id_pc       (id_pc_q),
        .id_instr    (id_instr_q),
        .npc_sel     (bus.npc_sel),
        .compare_out (bus.compare_out),
        .jr_target   (bus.jr_target),
        .id_valid    (id_valid_q),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = bus.stall ? ST_BOOT : ST_RUN;
                load    = !bus.stall;
            end
            ST_RUN: begin
                state_d = bus.stall ? ST_HOLD : ST_RUN;
                load    = !bus.stall;
            end
            ST_HOLD: begin
                state_d = bus.stall ? ST_HOLD : ST_RUN;
                load    = !bus.stall;
            end
            default: begin
                state_d = ST_BOOT;
                load    = 1'b0;
            end
        endcase
    end

    // A stalled redirect is simply not loaded; it is recomputed next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= RESET_PC;
            id_valid_q <= 1'b0;
        end else if (load) begin
            pc_q       <= next_pc;
            id_instr_q <= bus.im_instr;
            id_pc_q    <= pc_q;
            id_valid_q <= 1'b1;
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.id_instr = id_instr_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_pc8   = id_pc_q + 32'd8;
    assign bus.id_valid = id_valid_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: sequential fetch, branches,
// jumps, stalls, wrap-around and asynchronous reset.
module tb_pc_branch_unit;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    pc_branch_unit_if bus ();

    pc_branch_unit #(
        .RESET_PC  (32'h0000_3000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic st, input logic [1:0] sel,
                         input logic cmp, input logic [31:0] jr,
                         input logic [31:0] im);
        bus.stall       = st;
        bus.npc_sel     = sel;
        bus.compare_out = cmp;
        bus.jr_target   = jr;
        bus.im_instr    = im;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h1111_0000);
        @(negedge clk);
        step();

        chk("rst_pc", bus.pc_out, 32'h0000_3000);
        chk("rst_instr", bus.id_instr, 32'h0000_0000);
        chk("rst_idpc", bus.id_pc, 32'h0000_3000);
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_pc8", bus.id_pc8, 32'h0000_3008);

        // sequential fetch
        reset_n = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h1111_0000);
        step();
        chk("seq1_pc", bus.pc_out, 32'h0000_3004);
        chk("seq1_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("seq1_idpc", bus.id_pc, 32'h0000_3000);
        chk("seq1_pc8", bus.id_pc8, 32'h0000_3008);

        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h1000_FFFE);
        step();
        chk("seq2_pc", bus.pc_out, 32'h0000_3008);
        chk("seq2_idpc", bus.id_pc, 32'h0000_3004);
        chk("seq2_instr", bus.id_instr, 32'h1000_FFFE);

        // taken backward branch at 3004
        drive(1'b0, 2'b01, 1'b1, 32'h0, 32'h1000_FFFE);
        step();
        chk("br_t_pc", bus.pc_out, 32'h0000_3000);
        chk("br_t_idpc", bus.id_pc, 32'h0000_3008);

        // not-taken branch at 3008
        drive(1'b0, 2'b01, 1'b0, 32'h0, 32'h2222_0000);
        step();
        chk("br_nt_pc", bus.pc_out, 32'h0000_3004);
        chk("br_nt_idpc", bus.id_pc, 32'h0000_3000);

        // jr to 3010, then fetch the jump into ID
        drive(1'b0, 2'b11, 1'b0, 32'h0000_3010, 32'h3333_0000);
        step();
        chk("jr1_pc", bus.pc_out, 32'h0000_3010);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0800_0C40);
        step();
        chk("jfetch_pc", bus.pc_out, 32'h0000_3014);
        chk("jfetch_idpc", bus.id_pc, 32'h0000_3010);

        // jump with delay slot
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'hDDDD_0001);
        step();
        chk("j_pc", bus.pc_out, 32'h0000_3100);
        chk("ds_idpc", bus.id_pc, 32'h0000_3014);
        chk("ds_instr", bus.id_instr, 32'hDDDD_0001);
        chk("ds_pc8", bus.id_pc8, 32'h0000_301C);

        // jr held by a two-cycle stall
        drive(1'b1, 2'b11, 1'b0, 32'h0000_3ABC, 32'h4444_0000);
        step();
        chk("st1_pc", bus.pc_out, 32'h0000_3100);
        chk("st1_idpc", bus.id_pc, 32'h0000_3014);
        step();
        chk("st2_pc", bus.pc_out, 32'h0000_3100);
        chk("st2_instr", bus.id_instr, 32'hDDDD_0001);
        bus.stall = 1'b0;
        step();
        chk("jr_pc", bus.pc_out, 32'h0000_3ABC);
        chk("jr_idpc", bus.id_pc, 32'h0000_3100);

        // misaligned jr target is loaded as-is
        drive(1'b0, 2'b11, 1'b0, 32'h0000_3ABE, 32'h5555_0000);
        step();
        chk("jr_odd_pc", bus.pc_out, 32'h0000_3ABE);

        // branch at FFFF_FFF8 wraps to zero
        drive(1'b0, 2'b11, 1'b0, 32'hFFFF_FFF8, 32'h6666_0000);
        step();
        chk("wr_jr_pc", bus.pc_out, 32'hFFFF_FFF8);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h1000_0001);
        step();
        chk("wr_idpc", bus.id_pc, 32'hFFFF_FFF8);
        chk("wr_pc8", bus.id_pc8, 32'h0000_0000);
        drive(1'b0, 2'b01, 1'b1, 32'h0, 32'h7777_0000);
        step();
        chk("wr_br_pc", bus.pc_out, 32'h0000_0000);

        // asynchronous reset mid-stall
        drive(1'b1, 2'b11, 1'b1, 32'h0000_5000, 32'h8888_0000);
        step();
        reset_n = 1'b0;
        #1;
        chk("ar_pc", bus.pc_out, 32'h0000_3000);
        chk("ar_instr", bus.id_instr, 32'h0000_0000);
        chk("ar_idpc", bus.id_pc, 32'h0000_3000);
        chk("ar_valid", {31'd0, bus.id_valid}, 32'd0);
        bus.stall = 1'b0;
        step();
        chk("ar_hold_pc", bus.pc_out, 32'h0000_3000);

        // leave reset while stalled: BOOT holds
        bus.stall = 1'b1;
        reset_n   = 1'b1;
        step();
        chk("boot_st_pc", bus.pc_out, 32'h0000_3000);
        chk("boot_st_valid", {31'd0, bus.id_valid}, 32'd0);

        // redirect ignored while ID holds the bubble
        drive(1'b0, 2'b11, 1'b1, 32'h0000_5000, 32'h9999_0000);
        step();
        chk("bub_pc", bus.pc_out, 32'h0000_3004);
        chk("bub_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("bub_instr", bus.id_instr, 32'h9999_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
